cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for wide operands. Operands are split into GBIT-bit lookahead groups, and one group is resolved per pipeline stage, so throughput is one operation per clock at any width. A valid/ready handshake on both sides lets the block sit between streaming producers and consumers in the datapath. Carry-out and signed overflow are provided for multiword chaining and saturation logic.

---
 rtl/cla_adder_pipe.sv | 130 +++++++++++++
 tb/tb_cla_adder_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead adder/subtractor, one GBIT group per stage
module cla_adder_pipe #(
    parameter int NBIT = 16,
    parameter int GBIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            cout,
    output logic            ovf
);
    localparam int L = NBIT / GBIT;

    logic w_adv;
    logic r_ovf;

    // Every carry is a flat sum of products of g/p and the group carry-in; no c[i] feeds c[i+1].
    function automatic logic [GBIT:0] cla_carries(input logic [GBIT-1:0] g,
                                                  input logic [GBIT-1:0] p,
                                                  input logic            ci);
        logic [GBIT:0] c;
        logic          t;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GBIT; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_stage
            localparam int LO = k * GBIT;
            localparam int WI = NBIT - LO;
            localparam int WS = LO + GBIT;

            logic [WI-1:0]   w_a;
            logic [WI-1:0]   w_b;
            logic            w_ci;
            logic            w_vi;
            logic [GBIT-1:0] w_g;
            logic [GBIT-1:0] w_p;
            logic [GBIT-1:0] w_sum;
            logic [GBIT:0]   w_c;
            logic [WS-1:0]   w_s_nx;

            logic            r_v;
            logic            r_c;
            logic [WS-1:0]   r_s;

            if (k == 0) begin : g_entry
                assign w_a    = a;
                assign w_b    = sub ? ~b : b;
                assign w_ci   = cin;
                assign w_vi   = in_valid;
                assign w_s_nx = w_sum;
            end else begin : g_link
                assign w_a    = g_stage[k-1].g_skew.r_a;
                assign w_b    = g_stage[k-1].g_skew.r_b;
                assign w_ci   = g_stage[k-1].r_c;
                assign w_vi   = g_stage[k-1].r_v;
                assign w_s_nx = {w_sum, g_stage[k-1].r_s};
            end

            assign w_g   = w_a[GBIT-1:0] & w_b[GBIT-1:0];
            assign w_p   = w_a[GBIT-1:0] ^ w_b[GBIT-1:0];
            assign w_c   = cla_carries(w_g, w_p, w_ci);
            assign w_sum = w_p ^ w_c[GBIT-1:0];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_s <= '0;
                end else if (w_adv) begin
                    r_v <= w_vi;
                    r_c <= w_c[GBIT];
                    r_s <= w_s_nx;
                end
            end

            // Unresolved operand bits ride along with the beat to the stage that consumes them.
            if (k < L - 1) begin : g_skew
                logic [WI-GBIT-1:0] r_a;
                logic [WI-GBIT-1:0] r_b;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv) begin
                        r_a <= w_a[WI-1:GBIT];
                        r_b <= w_b[WI-1:GBIT];
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= w_c[GBIT-1] ^ w_c[GBIT];
                    end
                end
            end
        end
    endgenerate

    assign w_adv     = !out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = g_stage[L-1].r_v;
    assign s         = g_stage[L-1].r_s;
    assign cout      = g_stage[L-1].r_c;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - randomized and directed bench for cla_adder_pipe across several widths
module tb_cla_adder_pipe;
    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done [5];

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          acc;
        int          st;
        bit          lit;
        logic [63:0] ls;
        logic        lc;
        logic        lo;
    } exp_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Plain integer arithmetic: sum modulo 2^nb, carry is bit nb, overflow from operand/result signs.
    function automatic exp_t model(input int nb, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] yb;
        logic [63:0] full;
        mask  = (64'd1 << nb) - 64'd1;
        yb    = (sb ? ~y : y) & mask;
        full  = (x & mask) + yb + {63'd0, ci};
        e.s   = full & mask;
        e.c   = full[nb];
        e.o   = (x[nb-1] == yb[nb-1]) && (e.s[nb-1] != x[nb-1]);
        e.acc = 0;
        e.st  = 0;
        e.lit = 0;
        e.ls  = '0;
        e.lc  = 1'b0;
        e.lo  = 1'b0;
        return e;
    endfunction

    for (genvar I = 0; I < 5; I++) begin : g_cfg
        localparam int NB  = (I == 0) ? 16 : (I == 1) ? 4 : (I == 2) ? 8 : (I == 3) ? 32 : 8;
        localparam int GB  = (I == 4) ? 1 : 4;
        localparam int LAT = NB / GB;

        logic          rst_n;
        logic          in_valid;
        logic          in_ready;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic          cin;
        logic          sub;
        logic          out_valid;
        logic          out_ready;
        logic [NB-1:0] s;
        logic          cout;
        logic          ovf;

        bit            lit_en;
        logic [63:0]   lit_s;
        logic          lit_c;
        logic          lit_o;
        bit            rnd_or;

        exp_t          q[$];
        int            cyc      = 0;
        int            nst      = 0;
        bit            rst_seen = 0;
        bit            hold_v   = 0;
        logic [NB-1:0] hold_s;
        logic          hold_c;
        logic          hold_o;

        cla_adder_pipe #(.NBIT(NB), .GBIT(GB)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .s        (s),
            .cout     (cout),
            .ovf      (ovf)
        );

        task automatic cchk(input string nm, input logic [63:0] act, input logic [63:0] want);
            chk($sformatf("c%0d.%s", I, nm), act, want);
        endtask

        always @(negedge clk) begin : p_chk
            exp_t e;
            if (!rst_n) begin
                q.delete();
                rst_seen = 1;
                hold_v   = 0;
            end else begin
                if (rst_seen) begin
                    cchk("rst_out_valid", {63'd0, out_valid}, 64'd0);
                    cchk("rst_s", {{(64-NB){1'b0}}, s}, 64'd0);
                    cchk("rst_cout", {63'd0, cout}, 64'd0);
                    cchk("rst_ovf", {63'd0, ovf}, 64'd0);
                    cchk("rst_in_ready", {63'd0, in_ready}, 64'd1);
                    rst_seen = 0;
                end
                cchk("in_ready", {63'd0, in_ready}, {63'd0, !out_valid | out_ready});
                if (hold_v) begin
                    cchk("hold_valid", {63'd0, out_valid}, 64'd1);
                    cchk("hold_s", {{(64-NB){1'b0}}, s}, {{(64-NB){1'b0}}, hold_s});
                    cchk("hold_cout", {63'd0, cout}, {63'd0, hold_c});
                    cchk("hold_ovf", {63'd0, ovf}, {63'd0, hold_o});
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        cchk("spurious_beat", {63'd0, out_valid}, 64'd0);
                    end else if (out_ready) begin
                        e = q.pop_front();
                        cchk("sum", {{(64-NB){1'b0}}, s}, e.s);
                        cchk("cout", {63'd0, cout}, {63'd0, e.c});
                        cchk("ovf", {63'd0, ovf}, {63'd0, e.o});
                        cchk("latency", 64'(cyc - e.acc), 64'(LAT + nst - e.st));
                        if (e.lit) begin
                            cchk("lit_sum", {{(64-NB){1'b0}}, s}, e.ls);
                            cchk("lit_cout", {63'd0, cout}, {63'd0, e.lc});
                            cchk("lit_ovf", {63'd0, ovf}, {63'd0, e.lo});
                        end
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_s = s;
                hold_c = cout;
                hold_o = ovf;
                if (out_valid && !out_ready) nst++;
                if (in_valid && in_ready) begin
                    e     = model(NB, {{(64-NB){1'b0}}, a}, {{(64-NB){1'b0}}, b}, cin, sub);
                    e.acc = cyc;
                    e.st  = nst;
                    e.lit = lit_en;
                    e.ls  = lit_s;
                    e.lc  = lit_c;
                    e.lo  = lit_o;
                    q.push_back(e);
                end
            end
            cyc++;
        end

        task automatic idle();
            in_valid  = 1'b0;
            out_ready = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #2;
        endtask

        task automatic push(input logic [63:0] x, input logic [63:0] y, input logic ci,
                            input logic sb, input bit le, input logic [63:0] ls,
                            input logic lc, input logic lo);
            bit ok;
            ok       = 0;
            a        = x[NB-1:0];
            b        = y[NB-1:0];
            cin      = ci;
            sub      = sb;
            lit_en   = le;
            lit_s    = ls;
            lit_c    = lc;
            lit_o    = lo;
            in_valid = 1'b1;
            for (int t = 0; t < 200 && !ok; t++) begin
                out_ready = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                ok = in_ready;
                @(posedge clk);
                #2;
            end
            if (!ok) cchk("push_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            lit_en   = 0;
        endtask

        task automatic drain();
            rnd_or = 0;
            for (int t = 0; t < 300 && q.size() > 0; t++) idle();
            cchk("drain", 64'(q.size()), 64'd0);
        endtask

        task automatic start();
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            a         = '0;
            b         = '0;
            cin       = 1'b0;
            sub       = 1'b0;
            lit_en    = 0;
            lit_s     = '0;
            lit_c     = 1'b0;
            lit_o     = 1'b0;
            rnd_or    = 0;
            @(posedge clk);
            #2;
            @(posedge clk);
            #2;
            rst_n = 1'b1;
        endtask

        if (I == 0) begin : g_main
            initial begin
                start();
                push(64'hFFFF, 64'h0001, 1'b0, 1'b0, 1, 64'h0000, 1'b1, 1'b0);
                push(64'h7FFF, 64'h0001, 1'b0, 1'b0, 1, 64'h8000, 1'b0, 1'b1);
                push(64'h8000, 64'hFFFF, 1'b0, 1'b0, 1, 64'h7FFF, 1'b1, 1'b1);
                push(64'h0003, 64'h0005, 1'b1, 1'b1, 1, 64'hFFFE, 1'b0, 1'b0);
                push(64'h0003, 64'h0005, 1'b0, 1'b1, 1, 64'hFFFD, 1'b0, 1'b0);
                drain();
                rnd_or = 1;
                for (int n = 0; n < 20; n++)
                    push($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         0, '0, 1'b0, 1'b0);
                for (int n = 0; n < 12; n++) begin
                    if ($urandom_range(0, 2) == 0) idle();
                    push($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         0, '0, 1'b0, 1'b0);
                end
                drain();
                for (int n = 0; n < 3; n++)
                    push($urandom, $urandom, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
                rst_n    = 1'b0;
                in_valid = 1'b1;
                a        = 16'h1234;
                b        = 16'h4321;
                @(posedge clk);
                #2;
                rst_n    = 1'b1;
                in_valid = 1'b0;
                for (int n = 0; n < 8; n++) idle();
                push(64'h1111, 64'h2222, 1'b1, 1'b0, 1, 64'h3334, 1'b0, 1'b0);
                drain();
                done[I] = 1;
            end
        end else begin : g_sweep
            initial begin
                start();
                if (NB == 4) begin
                    for (int x = 0; x < 16; x++)
                        for (int y = 0; y < 16; y++)
                            for (int m = 0; m < 4; m++)
                                push(64'(x), 64'(y), m[0], m[1], 0, '0, 1'b0, 1'b0);
                end else if (NB == 8) begin
                    for (int x = 0; x < 256; x++) begin
                        push(64'(x), 64'hFF, 1'($urandom_range(0, 1)), 1'b0, 0, '0, 1'b0, 1'b0);
                        push(64'(x), 64'h00, 1'($urandom_range(0, 1)), 1'b1, 0, '0, 1'b0, 1'b0);
                        for (int y = 0; y < 22; y++)
                            push(64'(x), 64'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)), 0, '0, 1'b0, 1'b0);
                    end
                end else begin
                    push(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 1, 64'h0, 1'b1, 1'b0);
                    push(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1, 64'h8000_0000, 1'b0, 1'b1);
                    for (int n = 0; n < 500; n++)
                        push($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             0, '0, 1'b0, 1'b0);
                end
                drain();
                done[I] = 1;
            end
        end
    end

    initial begin
        for (int t = 0; t < 40000; t++) begin
            if (done[0] && done[1] && done[2] && done[3] && done[4]) break;
            @(posedge clk);
        end
        for (int i = 0; i < 5; i++) chk($sformatf("done%0d", i), {63'd0, done[i]}, 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
